mem_fill_check: RTL and testbench

Sequential RAM initializer and readback checker that sits directly upstream of a register-array memory bank and drives its write and read ports. On `start` it writes a deterministic address-derived pattern into every location 0..DEPTH-1. It then reads every location back, compares against the same pattern, and reports the error count, the first failing address and a one-cycle `done` pulse. This replaces procedural index-pattern init loops with synthesizable, cycle-exact hardware.

---
 rtl/mem_fill_check_if.sv | 36 +++
 rtl/mem_fill_check.sv | 232 +++++++++++++++++++++++
 tb/tb_mem_fill_check.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_fill_check_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_fill_check_if
// Description : Write/read port bundle between the fill+check engine and a
//               register-array memory bank. The master drives the strobes,
//               the shared address and the write data. The slave returns
//               the read data.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_fill_check_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 18
);
    logic              mem_we;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_we,
        output mem_re,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_we,
        input  mem_re,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_fill_check.sv
`default_nettype none
// ============================================================================
// Module      : mem_fill_check
// Description : Sequential memory initializer and readback checker. It writes
//               an address-derived pattern to locations 0..DEPTH-1. It then
//               reads every location back through a RD_LAT-deep compare
//               pipeline. It reports the mismatch count, the first failing
//               address and a one-cycle done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_fill_check #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 18,
    parameter int DEPTH  = 1718,
    parameter int RD_LAT = 1,
    parameter int ERR_W  = 16
) (
    input  wire                clk,
    input  wire                reset,
    input  wire                start,
    input  wire                pattern_sel,
    output logic               busy,
    output logic               done,
    output logic [ERR_W-1:0]   err_count,
    output logic [ADDR_W-1:0]  first_err_addr,
    output logic               err_flag,
    mem_fill_check_if.master   mem
);

    // Sequencer states. The width is wide enough for all five states.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FILL  = 3'd1,
        S_CHECK = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam int                c_PW          = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam logic [ADDR_W-1:0] c_LAST_ADDR   = ADDR_W'(DEPTH - 1);
    localparam logic [2:0]        c_DRAIN_LAST  = 3'(RD_LAT - 1);
    localparam logic [ERR_W-1:0]  c_ERR_MAX     = '1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   w_idx_nxt;
    logic [ADDR_W-1:0]   w_idx_inc;
    logic [2:0]          r_drain;
    logic [2:0]          w_drain_nxt;
    logic                r_psel;
    logic                w_psel_nxt;
    logic                w_start_acc;
    logic                w_busy_nxt;
    logic                w_done_nxt;
    logic                w_we_nxt;
    logic                w_re_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;

    // Compare pipeline: read-valid, expected data and address travel
    // alongside the memory read. They line up with mem_rdata at the last stage.
    logic                r_pv    [RD_LAT];
    logic [DATA_W-1:0]   r_pexp  [RD_LAT];
    logic [ADDR_W-1:0]   r_paddr [RD_LAT];
    logic                w_cmp_valid;
    logic                w_cmp_miss;

    // Pattern for address a: zero-extend or truncate to DATA_W, and invert
    // if requested.
    function automatic logic [DATA_W-1:0] f_pat(input logic [ADDR_W-1:0] a, input logic inv);
        logic [c_PW-1:0] w_ext;
        w_ext             = '0;
        w_ext[ADDR_W-1:0] = a;
        f_pat             = inv ? ~w_ext[DATA_W-1:0] : w_ext[DATA_W-1:0];
    endfunction

    assign w_idx_inc = r_idx + 1'b1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and next values for every registered output. At the
    // last address the index is not incremented, so it never wraps past
    // DEPTH-1.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_drain_nxt = r_drain;
        w_psel_nxt  = r_psel;
        w_start_acc = 1'b0;
        w_busy_nxt  = 1'b1;
        w_done_nxt  = 1'b0;
        w_we_nxt    = 1'b0;
        w_re_nxt    = 1'b0;
        w_addr_nxt  = '0;
        w_wdata_nxt = '0;
        case (r_state)
            S_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start) begin
                    w_state_nxt = S_FILL;
                    w_start_acc = 1'b1;
                    w_psel_nxt  = pattern_sel;
                    w_idx_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = '0;
                    w_wdata_nxt = f_pat('0, pattern_sel);
                end
            end
            S_FILL: begin
                if (r_idx == c_LAST_ADDR) begin
                    w_state_nxt = S_CHECK;
                    w_idx_nxt   = '0;
                    w_re_nxt    = 1'b1;
                    w_addr_nxt  = '0;
                end else begin
                    w_idx_nxt   = w_idx_inc;
                    w_we_nxt    = 1'b1;
                    w_addr_nxt  = w_idx_inc;
                    w_wdata_nxt = f_pat(w_idx_inc, r_psel);
                end
            end
            S_CHECK: begin
                if (r_idx == c_LAST_ADDR) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = '0;
                end else begin
                    w_idx_nxt  = w_idx_inc;
                    w_re_nxt   = 1'b1;
                    w_addr_nxt = w_idx_inc;
                end
            end
            S_DRAIN: begin
                if (r_drain == c_DRAIN_LAST) begin
                    w_state_nxt = S_DONE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_drain_nxt = r_drain + 3'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    // Register the counters and all memory-port and status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx         <= '0;
            r_drain       <= '0;
            r_psel        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_re    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
        end else begin
            r_idx         <= w_idx_nxt;
            r_drain       <= w_drain_nxt;
            r_psel        <= w_psel_nxt;
            busy          <= w_busy_nxt;
            done          <= w_done_nxt;
            mem.mem_we    <= w_we_nxt;
            mem.mem_re    <= w_re_nxt;
            mem.mem_addr  <= w_addr_nxt;
            mem.mem_wdata <= w_wdata_nxt;
        end
    end

    // Shift each issued read into the compare pipeline. Stage 0 is loaded
    // on the same edge at which the memory samples the read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int j = 0; j < RD_LAT; j++) begin
                r_pv[j]    <= 1'b0;
                r_pexp[j]  <= '0;
                r_paddr[j] <= '0;
            end
        end else begin
            r_pv[0]    <= mem.mem_re;
            r_pexp[0]  <= f_pat(mem.mem_addr, r_psel);
            r_paddr[0] <= mem.mem_addr;
            for (int j = 1; j < RD_LAT; j++) begin
                r_pv[j]    <= r_pv[j-1];
                r_pexp[j]  <= r_pexp[j-1];
                r_paddr[j] <= r_paddr[j-1];
            end
        end
    end

    assign w_cmp_valid = r_pv[RD_LAT-1];
    assign w_cmp_miss  = w_cmp_valid && (mem.mem_rdata != r_pexp[RD_LAT-1]);

    // Accumulate mismatches. The count saturates, and the first failing
    // address is kept until the next accepted start.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_count      <= '0;
            first_err_addr <= '0;
            err_flag       <= 1'b0;
        end else if (w_start_acc) begin
            err_count      <= '0;
            first_err_addr <= '0;
            err_flag       <= 1'b0;
        end else if (w_cmp_miss) begin
            if (err_count != c_ERR_MAX) begin
                err_count <= err_count + 1'b1;
            end
            if (!err_flag) begin
                first_err_addr <= r_paddr[RD_LAT-1];
                err_flag       <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_fill_check.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_fill_check
// Description : Two checker instances are exercised here. The default
//               instance is 1718 x 18 with RD_LAT=1. The small instance is
//               32 x 4 with RD_LAT=3, ERR_W=4 and a full 2^ADDR_W depth.
//               Each runs against a fault-injecting RAM model. A cycle-level
//               reference derived from the run-time rules predicts every
//               output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_fill_check;

    localparam int M_IDEAL = 0, M_STUCK0 = 1, M_ADDR = 2, M_ZERO = 3, M_RAND = 4;

    function automatic int dep(int k);  return (k == 0) ? 1718 : 32; endfunction
    function automatic int lat(int k);  return (k == 0) ? 1 : 3;     endfunction
    function automatic int dw(int k);   return (k == 0) ? 18 : 4;    endfunction
    function automatic int emax(int k); return (k == 0) ? 65535 : 15; endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_v [2];
    logic psel_v  [2];

    logic        busy_a, done_a, flag_a;
    logic [15:0] cnt_a;
    logic [10:0] first_a;
    logic        busy_b, done_b, flag_b;
    logic [3:0]  cnt_b;
    logic [4:0]  first_b;

    mem_fill_check_if #(.ADDR_W(11), .DATA_W(18)) if_a ();
    mem_fill_check_if #(.ADDR_W(5),  .DATA_W(4))  if_b ();

    mem_fill_check #(.ADDR_W(11), .DATA_W(18), .DEPTH(1718), .RD_LAT(1), .ERR_W(16)) dut_a (
        .clk(clk), .reset(reset), .start(start_v[0]), .pattern_sel(psel_v[0]),
        .busy(busy_a), .done(done_a), .err_count(cnt_a), .first_err_addr(first_a),
        .err_flag(flag_a), .mem(if_a)
    );

    mem_fill_check #(.ADDR_W(5), .DATA_W(4), .DEPTH(32), .RD_LAT(3), .ERR_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start_v[1]), .pattern_sel(psel_v[1]),
        .busy(busy_b), .done(done_b), .err_count(cnt_b), .first_err_addr(first_b),
        .err_flag(flag_b), .mem(if_b)
    );

    // Uniform view of both instances
    int busy_o [2], done_o [2], we_o [2], re_o [2], addr_o [2], wdata_o [2];
    int cnt_o [2], first_o [2], flag_o [2];
    always_comb begin
        busy_o[0]  = int'(busy_a);         busy_o[1]  = int'(busy_b);
        done_o[0]  = int'(done_a);         done_o[1]  = int'(done_b);
        we_o[0]    = int'(if_a.mem_we);    we_o[1]    = int'(if_b.mem_we);
        re_o[0]    = int'(if_a.mem_re);    re_o[1]    = int'(if_b.mem_re);
        addr_o[0]  = int'(if_a.mem_addr);  addr_o[1]  = int'(if_b.mem_addr);
        wdata_o[0] = int'(if_a.mem_wdata); wdata_o[1] = int'(if_b.mem_wdata);
        cnt_o[0]   = int'(cnt_a);          cnt_o[1]   = int'(cnt_b);
        first_o[0] = int'(first_a);        first_o[1] = int'(first_b);
        flag_o[0]  = int'(flag_a);         flag_o[1]  = int'(flag_b);
    end

    // ---------------- RAM environment with readback fault injection -------
    int ram      [2][2048];
    int mask     [2][2048];
    int sh       [2][4];
    int env_mode [2];

    function automatic int pat(int k, int a, bit s);
        int m;
        m = (1 << dw(k)) - 1;
        return s ? ((~a) & m) : (a & m);
    endfunction

    function automatic int readback(int k, int a, int stored);
        case (env_mode[k])
            M_STUCK0: return (a == 44) ? (stored & ~1) : stored;
            M_ADDR:   return pat(k, a, 1'b0);
            M_ZERO:   return 0;
            M_RAND:   return stored ^ mask[k][a];
            default:  return stored;
        endcase
    endfunction

    // RAM writes, plus a read pipeline RD_LAT deep. Junk data is returned on
    // cycles with no read.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (we_o[k] != 0) ram[k][addr_o[k]] <= wdata_o[k];
            sh[k][0] <= (re_o[k] != 0) ? readback(k, addr_o[k], ram[k][addr_o[k]]) : int'($urandom);
            for (int j = 1; j < 4; j++) sh[k][j] <= sh[k][j-1];
        end
    end
    assign if_a.mem_rdata = 18'(sh[0][0]);
    assign if_b.mem_rdata = 4'(sh[1][2]);

    // ---------------- reference model and per-cycle compare ---------------
    int vectors = 0, miscompares = 0;
    int n_run [2];                   // visible cycle index within a run, 0 = idle
    bit sel_l [2];
    int pre   [2][2048];             // mismatches among addresses 0..a
    int fmis  [2];                   // first mismatching address, -1 if none
    int h_cnt [2], h_first [2], h_flag [2];
    int done_pulses [2], bcnt [2], done_at [2];
    logic p_start [2], p_psel [2];
    logic p_reset = 1'b1;

    task automatic chk(input string name, input int k, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, k, $time, act, exp);
        end
    endtask

    // Error outputs once the compares for addresses 0..m have landed
    task automatic err_at(input int k, input int m, output int c, output int f, output int fl);
        int mm;
        if (m < 0) begin
            c = 0; f = 0; fl = 0;
        end else begin
            mm = (m > dep(k) - 1) ? dep(k) - 1 : m;
            c  = (pre[k][mm] > emax(k)) ? emax(k) : pre[k][mm];
            fl = (fmis[k] >= 0 && fmis[k] <= mm) ? 1 : 0;
            f  = (fl != 0) ? fmis[k] : 0;
        end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            n_run[k] = 0; h_cnt[k] = 0; h_first[k] = 0; h_flag[k] = 0;
            p_start[k] = 1'b0; p_psel[k] = 1'b0;
            done_pulses[k] = 0; bcnt[k] = 0; done_at[k] = 0; fmis[k] = -1;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                int d, l, last, n, ec, ef, efl, run, pv;
                d = dep(k); l = lat(k); last = 2 * d + l + 1;
                // advance over the edge that just passed
                if (reset || p_reset) begin
                    n_run[k] = 0; h_cnt[k] = 0; h_first[k] = 0; h_flag[k] = 0;
                end else if (n_run[k] == 0) begin
                    if (p_start[k]) begin
                        n_run[k] = 1;
                        sel_l[k] = p_psel[k];
                        run = 0; fmis[k] = -1;
                        for (int a = 0; a < d; a++) begin
                            pv = pat(k, a, sel_l[k]);
                            if (readback(k, a, pv) != pv) begin
                                run++;
                                if (fmis[k] < 0) fmis[k] = a;
                            end
                            pre[k][a] = run;
                        end
                    end
                end else if (n_run[k] == last) begin
                    n_run[k] = 0;
                    err_at(k, d - 1, h_cnt[k], h_first[k], h_flag[k]);
                end else begin
                    n_run[k]++;
                end
                // expected outputs for the visible cycle
                n = n_run[k];
                if (n == 0) begin
                    chk("busy", k, busy_o[k], 0);  chk("done", k, done_o[k], 0);
                    chk("we", k, we_o[k], 0);      chk("re", k, re_o[k], 0);
                    chk("addr", k, addr_o[k], 0);  chk("wdata", k, wdata_o[k], 0);
                    chk("err_count", k, cnt_o[k], h_cnt[k]);
                    chk("first_err_addr", k, first_o[k], h_first[k]);
                    chk("err_flag", k, flag_o[k], h_flag[k]);
                end else begin
                    chk("busy", k, busy_o[k], 1);
                    chk("done", k, done_o[k], (n == last) ? 1 : 0);
                    chk("we", k, we_o[k], (n <= d) ? 1 : 0);
                    chk("re", k, re_o[k], (n > d && n <= 2 * d) ? 1 : 0);
                    chk("addr", k, addr_o[k], (n <= d) ? n - 1 : (n <= 2 * d) ? n - d - 1 : 0);
                    chk("wdata", k, wdata_o[k], (n <= d) ? pat(k, n - 1, sel_l[k]) : 0);
                    err_at(k, n - d - l - 2, ec, ef, efl);
                    chk("err_count", k, cnt_o[k], ec);
                    chk("first_err_addr", k, first_o[k], ef);
                    chk("err_flag", k, flag_o[k], efl);
                end
                // run bookkeeping for the literal checks
                if (busy_o[k] != 0) bcnt[k]++;
                if (done_o[k] != 0) begin
                    done_pulses[k]++;
                    done_at[k] = bcnt[k];
                end
                p_start[k] = start_v[k];
                p_psel[k]  = psel_v[k];
            end
            p_reset = reset;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit ea, input bit sa, input bit eb, input bit sb);
        start_v[0] = ea; psel_v[0] = sa;
        start_v[1] = eb; psel_v[1] = sb;
        if (ea) begin bcnt[0] = 0; done_pulses[0] = 0; end
        if (eb) begin bcnt[1] = 0; done_pulses[1] = 0; end
        tick(1);
        start_v[0] = 1'b0; start_v[1] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int budget);
        int w;
        w = 0;
        while (done_pulses[k] == 0 && w < budget) begin
            tick(1);
            w++;
        end
        vectors++;
        if (done_pulses[k] == 0) begin
            miscompares++;
            $display("FAIL done_timeout dut%0d: got no done within %0d cycles, expected one", k, budget);
        end
    endtask

    task automatic rand_masks(input int k, input int rate);
        for (int a = 0; a < 2048; a++)
            mask[k][a] = ($urandom_range(0, rate - 1) == 0) ? int'($urandom_range(1, (1 << dw(k)) - 1)) : 0;
    endtask

    initial begin
        reset = 1'b1;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        psel_v[0]  = 1'b0; psel_v[1]  = 1'b0;
        env_mode[0] = M_IDEAL; env_mode[1] = M_IDEAL;
        tick(3);
        reset = 1'b0;
        tick(2);
        chk("reset_busy", 0, busy_o[0], 0);
        chk("reset_err_count", 1, cnt_o[1], 0);

        // Small instance: randomized fault masks and pattern polarity
        for (int r = 0; r < 8; r++) begin
            env_mode[1] = M_RAND;
            rand_masks(1, 4);
            launch(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
            wait_done(1, 200);
            tick(3);
        end

        // Ideal RAM on the big instance; all-zero readback on the small one
        env_mode[0] = M_IDEAL; env_mode[1] = M_ZERO;
        launch(1'b1, 1'b0, 1'b1, 1'b1);
        wait_done(1, 200);
        chk("b_done_cycle", 1, done_at[1], 68);
        wait_done(0, 4000);
        tick(3);
        chk("a_ram_1717", 0, ram[0][1717], 1717);
        chk("a_done_cycle", 0, done_at[0], 3438);
        chk("a_ideal_count", 0, cnt_o[0], 0);
        chk("a_ideal_flag", 0, flag_o[0], 0);
        chk("b_sat_count", 1, cnt_o[1], 15);
        chk("b_sat_first", 1, first_o[1], 0);
        chk("b_sat_flag", 1, flag_o[1], 1);

        // Bit 0 stuck at 0 on readback of address 44 (~44 has bit 0 set)
        env_mode[0] = M_STUCK0;
        launch(1'b1, 1'b1, 1'b0, 1'b0);
        wait_done(0, 4000);
        tick(3);
        chk("stuck_count", 0, cnt_o[0], 1);
        chk("stuck_first", 0, first_o[0], 44);
        chk("stuck_flag", 0, flag_o[0], 1);

        // Inverted pattern written, but the RAM reads back the plain address
        env_mode[0] = M_ADDR;
        launch(1'b1, 1'b1, 1'b0, 1'b0);
        wait_done(0, 4000);
        tick(3);
        chk("inv_ram_175", 0, ram[0][175], 32'h3FF50);
        chk("inv_count", 0, cnt_o[0], 1718);
        chk("inv_first", 0, first_o[0], 0);

        // start pulses during a run are ignored: at cycle 5 and in the done cycle
        env_mode[0] = M_IDEAL;
        launch(1'b1, 1'b0, 1'b0, 1'b0);
        tick(4);
        start_v[0] = 1'b1; tick(1); start_v[0] = 1'b0;
        tick(3432);
        start_v[0] = 1'b1; tick(1); start_v[0] = 1'b0;
        wait_done(0, 100);
        tick(5);
        chk("ign_done_cycle", 0, done_at[0], 3438);
        chk("ign_done_pulses", 0, done_pulses[0], 1);
        chk("ign_busy_after", 0, busy_o[0], 0);

        // Randomized sparse faults on the big instance
        env_mode[0] = M_RAND;
        rand_masks(0, 64);
        launch(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        wait_done(0, 4000);
        tick(3);

        // Reset during FILL aborts immediately, and no done follows
        env_mode[0] = M_IDEAL;
        launch(1'b1, 1'b0, 1'b0, 1'b0);
        tick(899);
        reset = 1'b1;
        #1;
        chk("abort_busy", 0, busy_o[0], 0);
        chk("abort_we", 0, we_o[0], 0);
        chk("abort_addr", 0, addr_o[0], 0);
        tick(3);
        reset = 1'b0;
        tick(3600);
        chk("abort_no_done", 0, done_pulses[0], 0);
        chk("abort_busy_idle", 0, busy_o[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
